// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared definitions for the ctrl_seq_p instruction sequencer.
//   opcode_e     : 3-bit opcode map (HLT..JMP); wider opcodes with any bit
//                  above bit 2 set are undefined.
//   ctrl_state_e : sequencer state encoding, also exported for debug.
//   op_reads_mem : true for opcodes whose operand is read from memory.
package ctrl_pkg;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_RD    = 4'd3,
    LOAD      = 4'd4,
    STO_SETUP = 4'd5,
    STO_WR    = 4'd6,
    JUMP      = 4'd7,
    SKIP      = 4'd8,
    DONE      = 4'd9,
    HALTED    = 4'd10,
    STEP_WAIT = 4'd11
  } ctrl_state_e;

  function automatic logic op_reads_mem(input opcode_e op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/ctrl_seq_p_beat_cnt.sv
// beat_cnt -- modulo-N beat counter shared by instruction fetch and skip.
//   clk, rst_n : falling-edge clock, asynchronous active-low reset
//   clear      : synchronous return to 0 (wins over enable)
//   enable     : advance one beat; wraps to 0 after N-1
//   value      : current beat index
//   last       : value == N-1
module beat_cnt #(
  parameter int N = 2,
  localparam int BW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          enable,
  output logic [BW-1:0] value,
  output logic          last
);

  localparam logic [BW-1:0] LAST_V = BW'(N - 1);

  logic [BW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST_V) ? '0 : cnt_q + BW'(1);
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign value = cnt_q;
  assign last  = (cnt_q == LAST_V);

endmodule

// File: rtl/ctrl_seq_p.sv
// ctrl_seq_p -- instruction-cycle control sequencer.
// State advances on the falling edge of clk. Outputs are decoded from the
// registered state, so asynchronous reset (state forced to IDLE) clears
// every output immediately, including wr/datactrl_ena mid-store.
//   opcode, zero          : instruction opcode and accumulator-zero flag
//   mem_rdy               : memory handshake (see below)
//   step_mode, step       : single-step enable and advance pulse
//   resume                : leave HALTED
//   rd, wr                : memory strobes (never both high)
//   load_ir/acc/pc,incr_pc: datapath controls
//   datactrl_ena          : data bus drive enable
//   halt, ill_op          : halted flag, undefined-opcode pulse
//   ir_beat               : fetch beat index (0 outside FETCH)
//   dbg_state             : current state, for observation
//
// Handshake: a memory beat is offered while rd or wr is high and completes
// in any cycle where mem_rdy=1 at the falling edge; the offer stays up until
// then. With WAIT_EN=0 every beat completes in its first cycle.
module ctrl_seq_p
  import ctrl_pkg::*;
#(
  parameter int OPW         = 3,
  parameter int FETCH_BEATS = 2,
  parameter int WAIT_EN     = 1,
  localparam int BW = (FETCH_BEATS > 1) ? $clog2(FETCH_BEATS) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_rdy,
  input  logic           step_mode,
  input  logic           step,
  input  logic           resume,
  output logic           rd,
  output logic           wr,
  output logic           load_ir,
  output logic           load_acc,
  output logic           load_pc,
  output logic           incr_pc,
  output logic           datactrl_ena,
  output logic           halt,
  output logic [BW-1:0]  ir_beat,
  output logic           ill_op,
  output ctrl_state_e    dbg_state
);

  ctrl_state_e   state_q, state_d;
  logic          rdy;
  logic          op_undef;
  opcode_e       op_lo;
  logic          beat_clr, beat_en, beat_last;
  logic [BW-1:0] beat;

  assign rdy   = (WAIT_EN != 0) ? mem_rdy : 1'b1;
  assign op_lo = opcode_e'(opcode[2:0]);

  // Opcode values of 8 and above exist only when the opcode is wider than 3.
  generate
    if (OPW > 3) begin : g_wide_op
      assign op_undef = |opcode[OPW-1:3];
    end else begin : g_narrow_op
      assign op_undef = 1'b0;
    end
  endgenerate

  // The counter idles at 0 outside FETCH/SKIP so both start from beat 0.
  assign beat_clr = (state_q != FETCH) && (state_q != SKIP);
  assign beat_en  = ((state_q == FETCH) && rdy) || (state_q == SKIP);

  beat_cnt #(.N(FETCH_BEATS)) u_beat_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (beat_clr),
    .enable (beat_en),
    .value  (beat),
    .last   (beat_last)
  );

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = FETCH;
      FETCH:     if (rdy && beat_last) state_d = DECODE;
      DECODE: begin
        if (op_undef) begin
          state_d = DONE;
        end else begin
          case (op_lo)
            OP_HLT:  state_d = HALTED;
            OP_SKZ:  state_d = zero ? SKIP : DONE;
            OP_STO:  state_d = STO_SETUP;
            OP_JMP:  state_d = JUMP;
            default: state_d = op_reads_mem(op_lo) ? MEM_RD : DONE;
          endcase
        end
      end
      MEM_RD:    if (rdy) state_d = LOAD;
      LOAD:      state_d = DONE;
      STO_SETUP: state_d = STO_WR;
      STO_WR:    if (rdy) state_d = DONE;
      JUMP:      state_d = DONE;
      SKIP:      if (beat_last) state_d = DONE;
      DONE:      state_d = step_mode ? STEP_WAIT : FETCH;
      STEP_WAIT: if (step || !step_mode) state_d = FETCH;
      HALTED:    if (resume) state_d = FETCH;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    rd           = 1'b0;
    wr           = 1'b0;
    load_ir      = 1'b0;
    load_acc     = 1'b0;
    load_pc      = 1'b0;
    incr_pc      = 1'b0;
    datactrl_ena = 1'b0;
    halt         = 1'b0;
    ill_op       = 1'b0;
    ir_beat      = '0;
    case (state_q)
      FETCH: begin
        rd      = 1'b1;
        load_ir = 1'b1;
        ir_beat = beat;
        incr_pc = rdy;   // only in the cycle the beat is accepted
      end
      DECODE:    ill_op = op_undef;
      MEM_RD:    rd = 1'b1;
      LOAD: begin
        rd       = 1'b1;
        load_acc = 1'b1;
      end
      STO_SETUP: datactrl_ena = 1'b1;
      STO_WR: begin
        wr           = 1'b1;
        datactrl_ena = 1'b1;
      end
      JUMP:      load_pc = 1'b1;
      SKIP:      incr_pc = 1'b1;
      HALTED:    halt = 1'b1;
      default:   ;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_ctrl_seq_p.sv
// Directed bench for ctrl_seq_p. Two instances:
//   index 0 : OPW=3, FETCH_BEATS=2, WAIT_EN=0
//   index 1 : OPW=4, FETCH_BEATS=3, WAIT_EN=1
// Inputs change just after a falling edge; outputs are sampled on the
// rising edge, half a cycle away from the active edge.
module tb_ctrl_seq_p;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       zero, mem_rdy, step_mode, step, resume;

  logic rd [2], wr [2], load_ir [2], load_acc [2], load_pc [2];
  logic incr_pc [2], de [2], halt [2], ill_op [2];
  ctrl_state_e st_dbg [2];
  logic [0:0] ir_beat0;
  logic [1:0] ir_beat1;

  int vectors = 0;
  int miscompares = 0;
  int sel = 0;

  // last sample and per-window counters
  ctrl_state_e s_st;
  logic [7:0]  s_str;
  logic        s_ill;
  logic [1:0]  s_beat;
  int cyc_n, lacc_cyc;
  int cnt_rd, cnt_wr, cnt_de, cnt_incr, cnt_lacc, cnt_ldir, cnt_lpc;
  int cnt_halt, cnt_ill, cnt_nonhalt;
  int both_seen = 0;

  always #5 clk = ~clk;

  ctrl_seq_p #(.OPW(3), .FETCH_BEATS(2), .WAIT_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode[2:0]), .zero(zero),
    .mem_rdy(mem_rdy), .step_mode(step_mode), .step(step), .resume(resume),
    .rd(rd[0]), .wr(wr[0]), .load_ir(load_ir[0]), .load_acc(load_acc[0]),
    .load_pc(load_pc[0]), .incr_pc(incr_pc[0]), .datactrl_ena(de[0]),
    .halt(halt[0]), .ir_beat(ir_beat0), .ill_op(ill_op[0]),
    .dbg_state(st_dbg[0])
  );

  ctrl_seq_p #(.OPW(4), .FETCH_BEATS(3), .WAIT_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_rdy(mem_rdy), .step_mode(step_mode), .step(step), .resume(resume),
    .rd(rd[1]), .wr(wr[1]), .load_ir(load_ir[1]), .load_acc(load_acc[1]),
    .load_pc(load_pc[1]), .incr_pc(incr_pc[1]), .datactrl_ena(de[1]),
    .halt(halt[1]), .ir_beat(ir_beat1), .ill_op(ill_op[1]),
    .dbg_state(st_dbg[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic clear_cnt();
    cyc_n = 0; lacc_cyc = -1;
    cnt_rd = 0; cnt_wr = 0; cnt_de = 0; cnt_incr = 0; cnt_lacc = 0;
    cnt_ldir = 0; cnt_lpc = 0; cnt_halt = 0; cnt_ill = 0; cnt_nonhalt = 0;
  endtask

  // One clock: sample at the rising edge, return just after the falling edge.
  task automatic run_cycle();
    @(posedge clk);
    s_st   = st_dbg[sel];
    s_str  = {rd[sel], wr[sel], load_ir[sel], load_acc[sel], load_pc[sel],
              incr_pc[sel], de[sel], halt[sel]};
    s_ill  = ill_op[sel];
    s_beat = (sel == 0) ? {1'b0, ir_beat0} : ir_beat1;
    cyc_n++;
    cnt_rd   += int'(rd[sel]);
    cnt_wr   += int'(wr[sel]);
    cnt_de   += int'(de[sel]);
    cnt_incr += int'(incr_pc[sel]);
    cnt_lacc += int'(load_acc[sel]);
    cnt_ldir += int'(load_ir[sel]);
    cnt_lpc  += int'(load_pc[sel]);
    cnt_halt += int'(halt[sel]);
    cnt_ill  += int'(ill_op[sel]);
    if (s_str[7:1] != '0) cnt_nonhalt++;
    if (load_acc[sel]) lacc_cyc = cyc_n;
    if (rd[sel] && wr[sel]) both_seen++;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run_cycle();
    run_cycle();
    rst_n = 1'b1;
  endtask

  // Run until the sampled state equals target; a missing state is a failure.
  task automatic wait_state(input ctrl_state_e target, input string tag);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      run_cycle();
      if (s_st == target) found = 1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; opcode = 4'd0; zero = 1'b0; mem_rdy = 1'b0;
    step_mode = 1'b0; step = 1'b0; resume = 1'b0;

    // LDA on instance 0 (WAIT_EN=0, mem_rdy held low and ignored)
    sel = 0; opcode = 4'(OP_LDA);
    rst_n = 1'b0;
    run_cycle();
    chk("reset_strobes", 32'(s_str), 32'd0);
    chk("reset_state", 32'(s_st), 32'(IDLE));
    run_cycle();
    rst_n = 1'b1;
    clear_cnt();
    run_cycle();
    chk("lda_idle_state", 32'(s_st), 32'(IDLE));
    chk("lda_idle_strobes", 32'(s_str), 32'd0);
    run_cycle();
    chk("lda_fetch0_beat", 32'(s_beat), 32'd0);
    chk("lda_fetch0_incr", 32'(s_str[2]), 32'd1);
    run_cycle();
    chk("lda_fetch1_beat", 32'(s_beat), 32'd1);
    for (int i = 0; i < 4; i++) run_cycle();
    chk("lda_done_state", 32'(s_st), 32'(DONE));
    chk("lda_rd_cycles", 32'(cnt_rd), 32'd4);
    chk("lda_incr_pulses", 32'(cnt_incr), 32'd2);
    chk("lda_load_ir", 32'(cnt_ldir), 32'd2);
    chk("lda_load_acc", 32'(cnt_lacc), 32'd1);
    chk("lda_load_acc_cycle", 32'(lacc_cyc), 32'd6);

    // STO on instance 1 with three wait cycles in STO_WR
    sel = 1; opcode = 4'(OP_STO); mem_rdy = 1'b1;
    do_reset();
    wait_state(DECODE, "sto_reach_decode");
    chk("sto_decode_strobes", 32'(s_str), 32'd0);
    clear_cnt();
    mem_rdy = 1'b0;
    for (int i = 0; i < 4; i++) run_cycle();
    mem_rdy = 1'b1;
    run_cycle();
    mem_rdy = 1'b0;
    run_cycle();
    chk("sto_done_state", 32'(s_st), 32'(DONE));
    chk("sto_wr_cycles", 32'(cnt_wr), 32'd4);
    chk("sto_de_cycles", 32'(cnt_de), 32'd5);
    chk("sto_rd_cycles", 32'(cnt_rd), 32'd0);

    // SKZ with zero=1: three skip pulses with mem_rdy low; zero changes after DECODE
    opcode = 4'(OP_SKZ); zero = 1'b1; mem_rdy = 1'b1;
    wait_state(DECODE, "skz1_reach_decode");
    clear_cnt();
    mem_rdy = 1'b0; zero = 1'b0;
    run_cycle();
    chk("skz1_skip_state", 32'(s_st), 32'(SKIP));
    for (int i = 0; i < 3; i++) run_cycle();
    chk("skz1_done_state", 32'(s_st), 32'(DONE));
    chk("skz1_incr_pulses", 32'(cnt_incr), 32'd3);
    chk("skz1_rd_cycles", 32'(cnt_rd), 32'd0);

    // SKZ with zero=0: no extra pulses
    mem_rdy = 1'b1;
    wait_state(DECODE, "skz0_reach_decode");
    clear_cnt();
    mem_rdy = 1'b0; zero = 1'b1;
    run_cycle();
    chk("skz0_done_state", 32'(s_st), 32'(DONE));
    run_cycle();
    chk("skz0_fetch_state", 32'(s_st), 32'(FETCH));
    chk("skz0_incr_pulses", 32'(cnt_incr), 32'd0);
    zero = 1'b0;

    // HLT: ten halted cycles, then resume
    opcode = 4'(OP_HLT); mem_rdy = 1'b1;
    wait_state(DECODE, "hlt_reach_decode");
    clear_cnt();
    for (int i = 0; i < 10; i++) run_cycle();
    chk("hlt_state", 32'(s_st), 32'(HALTED));
    chk("hlt_halt_cycles", 32'(cnt_halt), 32'd10);
    chk("hlt_other_strobes", 32'(cnt_nonhalt), 32'd0);
    resume = 1'b1;
    run_cycle();
    chk("hlt_resume_cycle_halt", 32'(s_str[0]), 32'd1);
    resume = 1'b0; mem_rdy = 1'b0;
    run_cycle();
    chk("hlt_after_resume_state", 32'(s_st), 32'(FETCH));
    chk("hlt_after_resume_halt", 32'(s_str[0]), 32'd0);

    // Undefined opcode 4'b1010 (low bits look like ADD)
    opcode = 4'b1010; mem_rdy = 1'b1;
    wait_state(DECODE, "ill_reach_decode");
    chk("ill_pulse", 32'(s_ill), 32'd1);
    chk("ill_decode_strobes", 32'(s_str), 32'd0);
    clear_cnt();
    run_cycle();
    chk("ill_done_state", 32'(s_st), 32'(DONE));
    chk("ill_done_strobes", 32'(s_str), 32'd0);
    run_cycle();
    chk("ill_refetch_state", 32'(s_st), 32'(FETCH));
    chk("ill_refetch_rd", 32'(s_str[7]), 32'd1);
    chk("ill_single_pulse", 32'(cnt_ill), 32'd0);

    // JMP in single-step mode
    opcode = 4'(OP_JMP); step_mode = 1'b1; mem_rdy = 1'b1;
    wait_state(DECODE, "jmp_reach_decode");
    clear_cnt();
    run_cycle();
    chk("jmp_load_pc", 32'(s_str[3]), 32'd1);
    run_cycle();
    chk("jmp_done_state", 32'(s_st), 32'(DONE));
    for (int i = 0; i < 3; i++) run_cycle();
    chk("jmp_step_wait_state", 32'(s_st), 32'(STEP_WAIT));
    chk("jmp_load_pc_pulses", 32'(cnt_lpc), 32'd1);
    chk("jmp_step_wait_quiet", 32'(cnt_nonhalt), 32'd1);
    step = 1'b1;
    run_cycle();
    step = 1'b0;
    run_cycle();
    chk("jmp_step_advance", 32'(s_st), 32'(FETCH));
    step_mode = 1'b0;

    // Reset asserted mid-store: strobes drop without a clock edge
    opcode = 4'(OP_STO); mem_rdy = 1'b1;
    wait_state(DECODE, "rst_reach_decode");
    mem_rdy = 1'b0;
    run_cycle();
    run_cycle();
    chk("rst_in_sto_wr", 32'(wr[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_wr", 32'(wr[1]), 32'd0);
    chk("rst_async_de", 32'(de[1]), 32'd0);
    chk("rst_async_state", 32'(st_dbg[1]), 32'(IDLE));
    run_cycle();
    rst_n = 1'b1; mem_rdy = 1'b1;
    run_cycle();
    chk("rst_idle_state", 32'(s_st), 32'(IDLE));
    chk("rst_idle_strobes", 32'(s_str), 32'd0);
    run_cycle();
    chk("rst_refetch_state", 32'(s_st), 32'(FETCH));
    chk("rst_refetch_beat", 32'(s_beat), 32'd0);
    chk("rst_refetch_rd", 32'(s_str[7]), 32'd1);

    chk("rd_wr_exclusive", 32'(both_seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ctrl_seq_p.md
CTRL_SEQ_P -- requirements
Module: ctrl_seq_p

Interface
REQ-001 The block SHALL have parameter OPW, default 3, giving the opcode width in bits (minimum 3).
REQ-002 The block SHALL have parameter FETCH_BEATS, default 2, giving the memory beats per instruction fetch (1..8).
REQ-003 The block SHALL have parameter WAIT_EN, default 1; when 0, mem_rdy is ignored and treated as 1.
REQ-004 The block SHALL provide these ports:
- clk  in  1  single clock; state and registered outputs update on the falling edge.
- rst_n  in  1  reset, asynchronous and active-low.
- opcode  in  OPW  decoded instruction opcode.
- zero  in  1  accumulator-zero flag.
- mem_rdy  in  1  memory beat-complete handshake.
- step_mode  in  1  single-step enable.
- step  in  1  single-step advance pulse.
- resume  in  1  leave HALTED.
- rd, wr  out  1 each  memory strobes.
- load_ir, load_acc, load_pc, incr_pc  out  1 each  datapath loads.
- datactrl_ena  out  1  data bus drive enable.
- halt  out  1  halted flag.
- ir_beat  out  clog2(FETCH_BEATS), minimum 1  current fetch beat index.
- ill_op  out  1  one-cycle pulse on an undefined opcode.

Function
REQ-005 The opcode map SHALL be: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP; values of 8 and above are undefined.
REQ-006 The states SHALL be IDLE, FETCH, DECODE, MEM_RD, LOAD, STO_SETUP, STO_WR, JUMP, SKIP, DONE, HALTED and STEP_WAIT.
REQ-007 IDLE SHALL last one cycle after reset release, with all outputs 0, then go to FETCH with ir_beat=0.
REQ-008 FETCH behaviour:
- Drives rd=1, load_ir=1 and ir_beat=beat.
- A beat is accepted in a cycle where mem_rdy=1; incr_pc=1 combinationally in that same cycle only.
- Beat increments on acceptance.
- After beat FETCH_BEATS-1 is accepted, go to DECODE and reset beat to 0.
REQ-009 DECODE SHALL last one cycle with all strobes 0 and branch as follows:
- HLT goes to HALTED.
- SKZ goes to SKIP if zero=1, otherwise DONE.
- ADD, AND, XOR and LDA go to MEM_RD.
- STO goes to STO_SETUP.
- JMP goes to JUMP.
- Undefined opcodes go to DONE, with ill_op=1 for that cycle.
REQ-010 MEM_RD SHALL drive rd=1 and hold until mem_rdy=1, then go to LOAD.
REQ-011 LOAD SHALL drive rd=1 and load_acc=1 for exactly one cycle, then go to DONE.
REQ-012 STO_SETUP SHALL drive datactrl_ena=1 for one cycle, then go to STO_WR.
REQ-013 STO_WR SHALL drive wr=1 and datactrl_ena=1, hold until mem_rdy=1, then go to DONE.
REQ-014 JUMP SHALL drive load_pc=1 for one cycle, then go to DONE.
REQ-015 SKIP SHALL drive incr_pc=1 for exactly FETCH_BEATS cycles, independent of mem_rdy, then go to DONE.
REQ-016 DONE SHALL last one cycle with all strobes 0, then go to STEP_WAIT if step_mode=1, otherwise to FETCH.
REQ-017 STEP_WAIT SHALL hold with all strobes 0 until step=1, then go to FETCH.
- If step_mode drops to 0 while in STEP_WAIT, the block goes to FETCH on the next edge.
REQ-018 HALTED SHALL hold halt=1 with all other strobes 0 until resume=1, then go to FETCH with halt=0.
REQ-019 rd and wr SHALL never be 1 in the same cycle.
REQ-020 When WAIT_EN=0, every wait state SHALL last exactly one cycle.
REQ-021 The zero input SHALL be sampled only in DECODE.

Reset
REQ-022 While rst_n=0, the block SHALL hold state IDLE, beat=0 and every output at 0, asynchronously.
REQ-023 Reset asserted mid-operation, including during STO_WR, SHALL drop wr and datactrl_ena in the same cycle without waiting for a clock edge.

Structure
REQ-024 The opcode constants and state encoding SHALL live in the shared package ctrl_pkg.
REQ-025 The fetch-beat counter SHALL be one sub-module, beat_cnt, with parameter N and ports clear, enable, value and last.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- With FETCH_BEATS=2, WAIT_EN=0 and opcode=LDA: rd is high for 4 cycles in total, incr_pc pulses twice, and load_acc pulses once, in cycle 6 after IDLE.
- With opcode=STO and mem_rdy low for 3 cycles in STO_WR: wr is high for exactly 4 cycles, datactrl_ena for 5 cycles, and rd stays 0.
- With opcode=SKZ, zero=1 and FETCH_BEATS=3: incr_pc pulses 3 more times after fetch; with zero=0 there are no extra pulses.
- With opcode=HLT: halt=1 is held for 10 cycles with resume=0; resume=1 takes the block to FETCH with halt=0 on the next edge.
- With OPW=4 and opcode=4'b1010: ill_op pulses once, there are no memory strobes, and the block fetches again.
- With rst_n pulled low during STO_WR: wr and datactrl_ena drop to 0 immediately; after release, IDLE lasts 1 cycle and then the fetch restarts with ir_beat=0.
